led_bank_ctrl: RTL

- Controller that owns the 4-LED bank (D1-D4) and the power LED (D5) on the 12 MHz board.
- Built-in pattern engine steps on a divided tick; modes are rotate, bounce, blink and off.
- A single external override requester can borrow the LED bank for a fixed number of ticks through a req/ack handshake.
- Sits between the top-level board wrapper and the LED pins; the wrapper maps outputs directly to pins.

---
 rtl/led_bank_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/led_bank_ctrl.sv
// LED bank controller: tick-divided pattern engine (rotate/bounce/blink/off)
// with a req/ack override that borrows the bank for OVR_HOLD ticks.
module led_bank_ctrl #(
  parameter int unsigned TICK_DIV = 12000000,
  parameter int unsigned OVR_HOLD = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode_in,
  input  logic       mode_load,
  input  logic       ovr_req,
  input  logic [3:0] ovr_pat,
  output logic       ovr_ack,
  output logic       busy,
  output logic       tick_out,
  output logic [3:0] leds,
  output logic       power_led
);

  localparam int unsigned HW = $clog2(OVR_HOLD + 1);

  typedef enum logic [1:0] {
    M_ROTATE = 2'd0,
    M_BOUNCE = 2'd1,
    M_BLINK  = 2'd2,
    M_OFF    = 2'd3
  } mode_t;

  typedef enum logic {
    S_RUN = 1'b0,
    S_OVR = 1'b1
  } state_t;

  logic [23:0]   cnt;
  mode_t         mode;
  mode_t         load_mode;
  logic [3:0]    pat;
  logic          dir_up;
  state_t        state;
  logic [HW-1:0] hold;

  logic          cnt_last;
  logic          tick_hit;
  logic          hold_last;
  logic [3:0]    step_pat;
  logic          step_dir;
  logic [3:0]    pat_nxt;
  logic          dir_nxt;

  assign load_mode = mode_t'(mode_in);
  assign cnt_last  = (cnt == 24'(TICK_DIV - 1));
  // A load on the same edge restarts the divider, so it suppresses the tick.
  assign tick_hit  = cnt_last && !mode_load;
  assign hold_last = (hold == HW'(OVR_HOLD - 1));

  always_comb begin
    step_pat = pat;
    step_dir = dir_up;
    case (mode)
      M_ROTATE: step_pat = {pat[2:0], pat[3]};
      M_BOUNCE: begin
        if (dir_up) begin
          if (pat[3]) begin
            step_pat = 4'b0100;
            step_dir = 1'b0;
          end else begin
            step_pat = {pat[2:0], 1'b0};
          end
        end else begin
          if (pat[0]) begin
            step_pat = 4'b0010;
            step_dir = 1'b1;
          end else begin
            step_pat = {1'b0, pat[3:1]};
          end
        end
      end
      M_BLINK:  step_pat = ~pat;
      M_OFF:    step_pat = '0;
      default:  step_pat = pat;
    endcase
  end

  // Next pattern: load reinitialises, ticks advance only while the engine owns the bank.
  always_comb begin
    pat_nxt = pat;
    dir_nxt = dir_up;
    if (mode_load) begin
      dir_nxt = 1'b1;
      case (load_mode)
        M_ROTATE, M_BOUNCE: pat_nxt = 4'b0001;
        M_BLINK:            pat_nxt = 4'b1111;
        default:            pat_nxt = '0;
      endcase
    end else if (tick_hit && (state == S_RUN)) begin
      pat_nxt = step_pat;
      dir_nxt = step_dir;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      tick_out  <= 1'b0;
      mode      <= M_ROTATE;
      pat       <= 4'b0001;
      dir_up    <= 1'b1;
      state     <= S_RUN;
      hold      <= '0;
      leds      <= 4'b0001;
      ovr_ack   <= 1'b0;
      busy      <= 1'b0;
      power_led <= 1'b0;
    end else begin
      cnt       <= (mode_load || cnt_last) ? '0 : cnt + 24'd1;
      tick_out  <= tick_hit;
      power_led <= 1'b1;
      ovr_ack   <= 1'b0;
      pat       <= pat_nxt;
      dir_up    <= dir_nxt;
      if (mode_load) begin
        mode <= load_mode;
      end
      case (state)
        S_RUN: begin
          if (ovr_req) begin
            state   <= S_OVR;
            ovr_ack <= 1'b1;
            busy    <= 1'b1;
            leds    <= ovr_pat;
            hold    <= '0;
          end else begin
            leds <= pat_nxt;
          end
        end
        S_OVR: begin
          if (tick_hit) begin
            hold <= hold + HW'(1);
            if (hold_last) begin
              state <= S_RUN;
              busy  <= 1'b0;
              leds  <= pat_nxt;
            end
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

endmodule
